// File: rtl/ads131_pkg.sv
// Shared definitions for the ADS131A0x frame parser: FSM encoding, sample
// width and CRC-16-CCITT constants used by the optional frame check.
package ads131_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STATUS = 2'd1,
        ST_CHAN   = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam int          ADS131_SAMPLE_W = 24;
    localparam logic [15:0] ADS131_CRC_POLY = 16'h1021;
    localparam logic [15:0] ADS131_CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/ads131_crc16_24.sv
// Combinational CRC-16-CCITT update over 24 data bits, MSB first,
// no reflection. Used only when ADS131_FRAME_CRC_EN is defined.
module ads131_crc16_24
    import ads131_pkg::*;
(
    input  logic [15:0]                crc_in,
    input  logic [ADS131_SAMPLE_W-1:0] data,
    output logic [15:0]                crc_out
);

    // Shift each data bit through the LFSR, highest bit first.
    always_comb begin
        crc_out = crc_in;
        for (int i = ADS131_SAMPLE_W - 1; i >= 0; i--) begin
            if (crc_out[15] ^ data[i])
                crc_out = {crc_out[14:0], 1'b0} ^ ADS131_CRC_POLY;
            else
                crc_out = {crc_out[14:0], 1'b0};
        end
    end

endmodule

// File: rtl/ads131_frame_parser.sv
// ADS131A0x frame parser: splits the MISO words of one chip-select frame into
// a status word and NUM_CH signed 24-bit samples and publishes the whole
// record with a one-cycle frame_valid strobe.
// Optional feature macro: ADS131_FRAME_CRC_EN (trailing CRC-16 word, CHECK state).
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for frame_start, words ignored
// ST_STATUS | expecting word 0 (device status)
// ST_CHAN   | expecting channel word idx
// ST_CHECK  | expecting trailing CRC word (CRC build only)
module ads131_frame_parser
    import ads131_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                              system_clock,
    input  logic                              reset,
    input  logic                              frame_start,
    input  logic                              word_valid,
    input  logic [31:0]                       word_data,
    output logic                              frame_valid,
    output logic [15:0]                       status_word,
    output logic [ADS131_SAMPLE_W*NUM_CH-1:0] ch_data,
    output logic [FRAME_CNT_W-1:0]            frame_seq,
    output logic [7:0]                        abort_count,
    output logic                              crc_error
);

    localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int               CH_W     = ADS131_SAMPLE_W * NUM_CH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    state_t                       state;
    logic [IDX_W-1:0]             idx;
    logic [15:0]                  sh_status;
    logic [CH_W-1:0]              sh_ch;
    logic [CH_W-1:0]              ch_merged;
    logic [ADS131_SAMPLE_W-1:0]   sample;
    logic                         unused_low_bits;

    assign sample          = word_data[31:8];
    assign unused_low_bits = ^word_data[7:0];

    // Shadow channel image with the current word dropped into slot idx.
    always_comb begin
        ch_merged = sh_ch;
        ch_merged[ADS131_SAMPLE_W*int'(idx) +: ADS131_SAMPLE_W] = sample;
    end

`ifdef ADS131_FRAME_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_in;
    logic [15:0] crc_next;

    // The status word restarts the running CRC from its seed.
    assign crc_in = (state == ST_STATUS) ? ADS131_CRC_INIT : crc_q;

    ads131_crc16_24 u_crc (
        .crc_in  (crc_in),
        .data    (sample),
        .crc_out (crc_next)
    );
`else
    assign crc_error = 1'b0;
`endif

    // Frame FSM, shadow capture and registered publication of the record.
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            sh_status   <= '0;
            sh_ch       <= '0;
            frame_valid <= 1'b0;
            status_word <= '0;
            ch_data     <= '0;
            frame_seq   <= '0;
            abort_count <= '0;
`ifdef ADS131_FRAME_CRC_EN
            crc_q       <= ADS131_CRC_INIT;
            crc_error   <= 1'b0;
`endif
        end else begin
            frame_valid <= 1'b0;
            if (frame_start) begin
                // A start always wins; any word on the same cycle is dropped.
                if (state != ST_IDLE && abort_count != 8'hFF)
                    abort_count <= abort_count + 8'd1;
                state <= ST_STATUS;
                idx   <= '0;
            end else if (word_valid) begin
                case (state)
                    ST_STATUS: begin
                        sh_status <= word_data[31:16];
                        idx       <= '0;
                        state     <= ST_CHAN;
`ifdef ADS131_FRAME_CRC_EN
                        crc_q     <= crc_next;
`endif
                    end
                    ST_CHAN: begin
                        sh_ch <= ch_merged;
                        idx   <= idx + IDX_W'(1);
`ifdef ADS131_FRAME_CRC_EN
                        crc_q <= crc_next;
                        if (idx == LAST_IDX)
                            state <= ST_CHECK;
`else
                        if (idx == LAST_IDX) begin
                            status_word <= sh_status;
                            ch_data     <= ch_merged;
                            frame_seq   <= frame_seq + FRAME_CNT_W'(1);
                            frame_valid <= 1'b1;
                            state       <= ST_IDLE;
                        end
`endif
                    end
`ifdef ADS131_FRAME_CRC_EN
                    ST_CHECK: begin
                        crc_error   <= (word_data[31:16] != crc_q);
                        status_word <= sh_status;
                        ch_data     <= sh_ch;
                        frame_seq   <= frame_seq + FRAME_CNT_W'(1);
                        frame_valid <= 1'b1;
                        state       <= ST_IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ads131_frame_parser.sv
// Directed testbench for ads131_frame_parser (NUM_CH=4, FRAME_CNT_W=4).
module tb_ads131_frame_parser;

    localparam int NUM_CH = 4;
    localparam int FW     = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              frame_start = 1'b0;
    logic              word_valid = 1'b0;
    logic [31:0]       word_data = '0;
    logic              frame_valid;
    logic [15:0]       status_word;
    logic [24*NUM_CH-1:0] ch_data;
    logic [FW-1:0]     frame_seq;
    logic [7:0]        abort_count;
    logic              crc_error;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;

    logic [31:0] nom [5];
    logic [31:0] alt [5];

    ads131_frame_parser #(.NUM_CH(NUM_CH), .FRAME_CNT_W(FW)) dut (
        .system_clock (clk),
        .reset        (reset),
        .frame_start  (frame_start),
        .word_valid   (word_valid),
        .word_data    (word_data),
        .frame_valid  (frame_valid),
        .status_word  (status_word),
        .ch_data      (ch_data),
        .frame_seq    (frame_seq),
        .abort_count  (abort_count),
        .crc_error    (crc_error)
    );

    always #10 clk = ~clk;

    always @(posedge clk) if (frame_valid === 1'b1) fv_cnt++;

    // Byte-oriented CRC-16-CCITT reference over the 24 data bits of a word.
    function automatic logic [15:0] crc_bytes(input logic [15:0] c, input logic [23:0] d);
        logic [7:0] by;
        for (int b = 2; b >= 0; b--) begin
            by = d[b*8 +: 8];
            c  = c ^ {by, 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        word_valid = 1'b1;
        word_data  = w;
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    // Start plus all words of a frame; returns at the negedge where the
    // record strobe should be visible.
    task automatic send_frame(input logic [31:0] w [5], input bit bad_crc);
        logic [15:0] c;
        c = 16'hFFFF;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            c = crc_bytes(c, w[i][31:8]);
            send_word(w[i]);
        end
`ifdef ADS131_FRAME_CRC_EN
        send_word({c ^ {15'd0, bad_crc}, 16'h0000});
`else
        if (bad_crc) c = ~c;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({status_word, ch_data, frame_seq, abort_count, frame_valid, crc_error} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got status=%h ch=%h seq=%0d abort=%0d fv=%b crc=%b exp all zero",
                     status_word, ch_data, frame_seq, abort_count, frame_valid, crc_error);
        end
    endtask

    task automatic test_nominal();
        int fv0;
        fv0 = fv_cnt;
        send_frame(nom, 1'b0);
        checks++;
        if (frame_valid !== 1'b1) begin
            failures++; $display("FAIL nominal_latency got fv=%b exp 1", frame_valid);
        end
        checks++;
        if (status_word !== 16'h2200) begin
            failures++; $display("FAIL nominal_status got %h exp 2200", status_word);
        end
        checks++;
        if (ch_data !== 96'h800000_000001_FEDCBA_123456) begin
            failures++; $display("FAIL nominal_ch got %h exp 800000000001fedcba123456", ch_data);
        end
        checks++;
        if (frame_seq !== 4'd1) begin
            failures++; $display("FAIL nominal_seq got %0d exp 1", frame_seq);
        end
        checks++;
        if (crc_error !== 1'b0) begin
            failures++; $display("FAIL nominal_crc got %b exp 0", crc_error);
        end
        @(negedge clk);
        checks++;
        if (frame_valid !== 1'b0) begin
            failures++; $display("FAIL nominal_single_pulse got fv=%b exp 0", frame_valid);
        end
        // Trailing words in IDLE must be ignored.
        send_word(32'h7777_7700);
        send_word(32'h6666_6600);
        @(negedge clk);
        checks++;
        if (fv_cnt - fv0 !== 1 || status_word !== 16'h2200 || frame_seq !== 4'd1) begin
            failures++;
            $display("FAIL idle_words_ignored got frames=%0d status=%h seq=%0d exp 1/2200/1",
                     fv_cnt - fv0, status_word, frame_seq);
        end
    endtask

    task automatic test_abort();
        int fv0;
        fv0 = fv_cnt;
        pulse_start();
        send_word(32'h1111_0000);
        send_word(32'h0A0B0C_00);
        send_frame(alt, 1'b0);
        @(negedge clk);
        checks++;
        if (abort_count !== 8'd1) begin
            failures++; $display("FAIL abort_count got %0d exp 1", abort_count);
        end
        checks++;
        if (fv_cnt - fv0 !== 1) begin
            failures++; $display("FAIL abort_frames got %0d exp 1", fv_cnt - fv0);
        end
        checks++;
        if (status_word !== 16'h3300 || ch_data !== 96'h7FFFFF_FFFFFF_000100_ABCDEF) begin
            failures++;
            $display("FAIL abort_record got status=%h ch=%h exp 3300/7fffffffffff000100abcdef",
                     status_word, ch_data);
        end
        checks++;
        if (frame_seq !== 4'd2) begin
            failures++; $display("FAIL abort_seq got %0d exp 2", frame_seq);
        end
    endtask

    task automatic test_collision();
        frame_start = 1'b1;
        word_valid  = 1'b1;
        word_data   = 32'hAAAA_0000;
        @(negedge clk);
        frame_start = 1'b0;
        word_valid  = 1'b0;
        send_word(32'h5555_0000);
        send_word(32'h000010_00);
        send_word(32'h000020_00);
        send_word(32'h000030_00);
        send_word(32'h000040_00);
`ifdef ADS131_FRAME_CRC_EN
        begin
            logic [15:0] c;
            c = crc_bytes(16'hFFFF, 24'h555500);
            c = crc_bytes(c, 24'h000010);
            c = crc_bytes(c, 24'h000020);
            c = crc_bytes(c, 24'h000030);
            c = crc_bytes(c, 24'h000040);
            send_word({c, 16'h0000});
        end
`endif
        checks++;
        if (status_word !== 16'h5555 || ch_data !== 96'h000040_000030_000020_000010) begin
            failures++;
            $display("FAIL collision_record got status=%h ch=%h exp 5555/000040000030000020000010",
                     status_word, ch_data);
        end
        checks++;
        if (abort_count !== 8'd1 || frame_seq !== 4'd3) begin
            failures++; $display("FAIL collision_counts got abort=%0d seq=%0d exp 1/3", abort_count, frame_seq);
        end
    endtask

    task automatic test_async_reset();
        int fv0;
        pulse_start();
        send_word(32'h1234_0000);
        send_word(32'h111111_00);
        send_word(32'h222222_00);
        fv0 = fv_cnt;
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({status_word, ch_data, frame_seq, abort_count, frame_valid, crc_error} !== '0) begin
            failures++;
            $display("FAIL async_reset got status=%h ch=%h seq=%0d abort=%0d exp all zero",
                     status_word, ch_data, frame_seq, abort_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (fv_cnt !== fv0) begin
            failures++; $display("FAIL async_reset_no_frame got %0d frames exp 0", fv_cnt - fv0);
        end
        send_frame(nom, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || status_word !== 16'h2200 ||
            ch_data !== 96'h800000_000001_FEDCBA_123456 || frame_seq !== 4'd1) begin
            failures++;
            $display("FAIL post_reset_frame got fv=%b status=%h ch=%h seq=%0d exp 1/2200/nominal/1",
                     frame_valid, status_word, ch_data, frame_seq);
        end
    endtask

    task automatic test_saturation();
        frame_start = 1'b1;
        for (int i = 0; i < 301; i++) @(negedge clk);
        frame_start = 1'b0;
        checks++;
        if (abort_count !== 8'd255) begin
            failures++; $display("FAIL abort_saturate got %0d exp 255", abort_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) send_frame(nom, 1'b0);
        checks++;
        if (frame_seq !== 4'd0) begin
            failures++; $display("FAIL seq_wrap16 got %0d exp 0", frame_seq);
        end
        send_frame(nom, 1'b0);
        checks++;
        if (frame_seq !== 4'd1) begin
            failures++; $display("FAIL seq_wrap17 got %0d exp 1", frame_seq);
        end
    endtask

`ifdef ADS131_FRAME_CRC_EN
    task automatic test_crc();
        send_frame(nom, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || crc_error !== 1'b0) begin
            failures++; $display("FAIL crc_good got fv=%b err=%b exp 1/0", frame_valid, crc_error);
        end
        send_frame(alt, 1'b1);
        checks++;
        if (frame_valid !== 1'b1 || crc_error !== 1'b1 || status_word !== 16'h3300) begin
            failures++;
            $display("FAIL crc_bad got fv=%b err=%b status=%h exp 1/1/3300", frame_valid, crc_error, status_word);
        end
    endtask
`endif

    initial begin
        nom[0] = 32'h2200_0000; nom[1] = 32'h123456_00; nom[2] = 32'hFEDCBA_00;
        nom[3] = 32'h000001_00; nom[4] = 32'h800000_00;
        alt[0] = 32'h3300_0000; alt[1] = 32'hABCDEF_00; alt[2] = 32'h000100_00;
        alt[3] = 32'hFFFFFF_00; alt[4] = 32'h7FFFFF_00;
        test_reset();
        test_nominal();
        test_abort();
        test_collision();
        test_async_reset();
        test_saturation();
        test_wrap();
`ifdef ADS131_FRAME_CRC_EN
        test_crc();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ads131_frame_parser.md
# ads131_frame_parser

Downstream consumer of the ADS131A0X SPI master. It takes the 32-bit words the master shifts in from SPI_MISO during one chip-select frame and splits them into a status word and per-channel 24-bit signed samples. It presents the complete frame as one registered, single-cycle-strobed record to the acquisition logic. It runs entirely in the system_clock domain and never drives SPI pins.

## Interface
- NUM_CH, 4: ADC channels per frame, 1..4.
- FRAME_CNT_W, 16: width of the frame sequence counter.
- system_clock  in  1  50 MHz system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at CS assertion; begins a new frame.
- word_valid  in  1  one-cycle strobe; word_data holds a complete MISO word.
- word_data  in  32  MISO word, MSB first; device data in bits [31:8].
- frame_valid  out  1  one-cycle strobe; all record outputs updated this cycle.
- status_word  out  16  word 0, bits [31:16] (device response/status).
- ch_data  out  24*NUM_CH  channel n occupies [24n+23:24n], two's complement.
- frame_seq  out  FRAME_CNT_W  count of completed frames, wraps.
- abort_count  out  8  frames cut short by frame_start, saturates at 255.
- crc_error  out  1  valid with frame_valid (0 when CRC not compiled in).

## Operation
- FSM states: IDLE, STATUS, CHAN, CHECK (CHECK exists only with the CRC option).
- IDLE:
  - frame_start moves to STATUS and clears the word index.
  - word_valid is ignored.
- STATUS:
  - word_valid latches word_data[31:16] into a shadow status register.
  - Then moves to CHAN with index 0.
- CHAN:
  - Each word_valid stores word_data[31:8] into shadow channel[index] and increments index.
  - On index NUM_CH-1, moves to CHECK if CRC is enabled, otherwise completes the frame.
- CHECK:
  - The next word_valid compares word_data[31:16] against the running CRC.
  - Then completes the frame.
- Frame completion:
  - Shadow registers copy to status_word and ch_data.
  - frame_seq increments.
  - frame_valid pulses.
  - FSM returns to IDLE.
- Outputs hold their values between completions. A partial frame never alters them.
- frame_start in any non-IDLE state:
  - Abandons the partial frame.
  - abort_count increments, saturating at 255.
  - FSM restarts in STATUS.
- frame_start and word_valid in the same cycle: frame_start wins and the word is dropped.
- Extra words after completion, while in IDLE, are ignored.
- frame_seq wraps from all-ones to 0.

## Timing
- Reset values:
  - FSM in IDLE, index 0.
  - status_word 0, ch_data 0, frame_seq 0, abort_count 0.
  - frame_valid 0, crc_error 0.
- Latency: frame_valid rises on the cycle after the rising edge that samples the last word_valid, so exactly one clock.
- Back-to-back word_valid on consecutive cycles is accepted. No minimum spacing is required.
- Reset mid-frame discards everything. No frame_valid is produced.

## Configuration
- ADS131_FRAME_CRC_EN defined:
  - Each frame carries one extra trailing CRC word, so a frame is NUM_CH+2 words.
  - CRC is CRC-16-CCITT, polynomial 0x1021, initial value 0xFFFF, no reflection, no final XOR.
  - It covers word_data[31:8] of the status word and every channel word, MSB first.
  - crc_error = (received != computed), registered with frame_valid.
- Not defined:
  - A frame is NUM_CH+1 words.
  - No CHECK state and no CRC logic.
  - crc_error is tied 0.

## Structure
- Shared package ads131_pkg holds:
  - the FSM state encoding;
  - ADS131_SAMPLE_W = 24;
  - ADS131_CRC_POLY = 16'h1021;
  - ADS131_CRC_INIT = 16'hFFFF.
- One sub-module, ads131_crc16_24: combinational next-CRC from the current CRC and 24 data bits.
- ads131_crc16_24 is instantiated only under ADS131_FRAME_CRC_EN.

## Test plan
- Nominal frame, NUM_CH=4, CRC off:
  - Stimulus: frame_start, then words 0x2200_0000, 0x123456_00, 0xFEDCBA_00, 0x000001_00, 0x800000_00.
  - Required response: frame_valid once, one cycle after the last word.
  - status_word = 0x2200.
  - ch_data = {0x800000, 0x000001, 0xFEDCBA, 0x123456}.
  - frame_seq = 1.
- Abort:
  - Stimulus: frame_start, then 2 words, then frame_start, then a full 5-word frame.
  - Required response: abort_count = 1 and exactly one frame_valid.
  - Outputs reflect only the second frame.
- Collision:
  - Stimulus: frame_start coincident with word_valid carrying 0xAAAA_0000, followed by a full frame.
  - Required response: 0xAAAA is never seen in status_word.
- Saturation and wrap:
  - Stimulus: 300 aborted frames.
  - Required response: abort_count = 255.
  - Stimulus: with FRAME_CNT_W=4, 17 good frames.
  - Required response: frame_seq = 1.
- Async reset mid-frame:
  - Stimulus: assert reset after 3 words.
  - Required response: all outputs return to 0 immediately, with no clock needed, and no frame_valid.
  - A following full frame parses normally.
- CRC, with ADS131_FRAME_CRC_EN:
  - Stimulus: nominal frame plus the correct CRC word.
  - Required response: crc_error = 0.
  - Stimulus: the same frame with CRC bit 0 flipped.
  - Required response: crc_error = 1, and data is still published.
